// File: rtl/ppong_rd_ctrl.sv
// Ping-pong bank reader: drains two RAM banks alternately in column-major
// (corner-turn) order onto an AXI-Stream master through a 2-entry skid buffer.
module ppong_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDRW      = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            bank_rdy,
    output logic [1:0]            bank_rel,
    output logic [1:0]            enb,
    output logic [ADDRW-1:0]      addrb,
    input  logic [DATA_WIDTH-1:0] dob0,
    input  logic [DATA_WIDTH-1:0] dob1,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            dbg_state
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    cur_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic [DATA_WIDTH-1:0]   buf_data_q [2];
    logic [1:0]              buf_last_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic [1:0]              bank_rel_q;

    logic [DATA_WIDTH-1:0]   dob_sel;
    logic                    bypass;
    logic                    head_last;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    last_addr;
    logic [1:0]              occ;
    logic [RW-1:0]           row_d;
    logic [CW-1:0]           col_d;
    logic [1:0]              count_d;

    // With the buffer empty, the in-flight RAM word is forwarded straight to
    // the stream; this keeps the inter-bank bubble to two cycles.
    always_comb begin
        dob_sel       = cur_q ? dob1 : dob0;
        bypass        = (count_q == 2'd0);
        m_axis_tvalid = !bypass || inflight_q;
        head_last     = bypass ? inflight_last_q : buf_last_q[rd_ptr_q];
        m_axis_tlast  = m_axis_tvalid && head_last;
        m_axis_tdata  = '0;
        if (!bypass) begin
            m_axis_tdata = buf_data_q[rd_ptr_q];
        end else if (inflight_q) begin
            m_axis_tdata = dob_sel;
        end
        pop       = m_axis_tvalid && m_axis_tready;
        push      = inflight_q && !(bypass && pop);
        occ       = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue     = (state_q == READ) && (occ < 2'd2);
        enb       = 2'b00;
        if (issue) begin
            enb[cur_q] = 1'b1;
        end
        last_addr = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
        if (row_q == RW'(ROWS - 1)) begin
            row_d = '0;
            col_d = col_q + 1'b1;
        end else begin
            row_d = row_q + 1'b1;
            col_d = col_q;
        end
        count_d   = count_q + {1'b0, push} - {1'b0, pop && !bypass};
    end

    assign addrb     = ADDRW'(row_q) * ADDRW'(COLS) + ADDRW'(col_q);
    assign bank_rel  = bank_rel_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            cur_q           <= 1'b0;
            row_q           <= '0;
            col_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q      <= 2'b00;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            bank_rel_q      <= 2'b00;
        end else begin
            bank_rel_q      <= 2'b00;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_addr;
            count_q         <= count_d;

            if (push) begin
                buf_data_q[wr_ptr_q] <= dob_sel;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop && !bypass) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            // bank_rdy is only looked at in IDLE, so a writer dropping it
            // mid-read cannot disturb the current bank.
            case (state_q)
                IDLE: begin
                    row_q <= '0;
                    col_q <= '0;
                    if (bank_rdy[cur_q]) begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (last_addr) begin
                            state_q <= DRAIN;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else begin
                            row_q <= row_d;
                            col_q <= col_d;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state_q           <= IDLE;
                        bank_rel_q[cur_q] <= 1'b1;
                        cur_q             <= ~cur_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppong_rd_ctrl.sv
// Directed bench for ppong_rd_ctrl: two modelled RAM banks (bank 0 = address,
// bank 1 = 0x100 + address) and a stream monitor feeding hand-built expectations.
module tb_ppong_rd_ctrl;

    localparam int DW    = 32;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ADDRW = 6;

    logic             clk = 1'b0;
    logic             resetn;
    logic [1:0]       bank_rdy;
    logic [1:0]       bank_rel;
    logic [1:0]       enb;
    logic [ADDRW-1:0] addrb;
    logic [DW-1:0]    dob0 = '0;
    logic [DW-1:0]    dob1 = '0;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [1:0]       dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    ppong_rd_ctrl #(
        .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDRW(ADDRW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bank_rdy      (bank_rdy),
        .bank_rel      (bank_rel),
        .enb           (enb),
        .addrb         (addrb),
        .dob0          (dob0),
        .dob1          (dob1),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models, one cycle latency after enb.
    always @(posedge clk) begin
        if (enb[0]) dob0 <= DW'(addrb);
        if (enb[1]) dob1 <= 32'h100 + DW'(addrb);
    end

    // Monitor, sampled on the falling edge.
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int            got_t [$];
    int            cyc       = 0;
    int            enb_cnt   = 0;
    int            tv_cnt    = 0;
    int            rel0_cnt  = 0;
    int            rel1_cnt  = 0;
    int            stall_err = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (enb != 2'b00) enb_cnt++;
            if (m_axis_tvalid) tv_cnt++;
            if (bank_rel[0]) rel0_cnt++;
            if (bank_rel[1]) rel1_cnt++;
            if (resetn && m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
                got_t.push_back(cyc);
            end
            if (resetn && stall_prev &&
                ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} != {1'b1, held_l, held_d}))
                stall_err++;
            stall_prev = resetn && m_axis_tvalid && !m_axis_tready;
            held_d     = m_axis_tdata;
            held_l     = m_axis_tlast;
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        resetn        = 1'b0;
        bank_rdy      = 2'b00;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ctrl", DW'({m_axis_tvalid, m_axis_tlast, enb, bank_rel, addrb}), '0);
        check("rst_data", m_axis_tdata, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic run_beats(input int target, input int budget, input bit rnd);
        int k = 0;
        while (got_d.size() < target && k < budget) begin
            @(posedge clk);
            #1;
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            k++;
        end
        check("beat_budget", DW'(got_d.size()), DW'(target));
    endtask

    task automatic check_stream(input int base, input int nbanks);
        int i = base;
        for (int b = 0; b < nbanks; b++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (i < got_d.size()) begin
                        check("beat_data", got_d[i], DW'(b * 256 + r * COLS + c));
                        check("beat_last", DW'(got_l[i]), DW'((r == ROWS - 1) && (c == COLS - 1)));
                    end
                    i++;
                end
            end
        end
    endtask

    initial begin
        int base;
        int r0;
        int r1;
        int e0;
        int t0;
        int s0;
        int gap;

        // Single bank, free-running sink.
        apply_reset();
        base = got_d.size(); r0 = rel0_cnt; r1 = rel1_cnt;
        bank_rdy = 2'b01; m_axis_tready = 1'b1;
        run_beats(base + 64, 400, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_stream(base, 1);
        check("single_count", DW'(got_d.size() - base), 32'd64);
        check("single_rel0", DW'(rel0_cnt - r0), 32'd1);
        check("single_rel1", DW'(rel1_cnt - r1), 32'd0);

        // Both banks back to back.
        apply_reset();
        base = got_d.size(); r0 = rel0_cnt; r1 = rel1_cnt;
        bank_rdy = 2'b11; m_axis_tready = 1'b1;
        run_beats(base + 128, 600, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_stream(base, 2);
        check("bank0_span", DW'(got_t[base + 63] - got_t[base]), 32'd63);
        gap = got_t[base + 64] - got_t[base + 63] - 1;
        check("bank_gap_le2", DW'(gap <= 2), 32'd1);
        check("dual_rel0", DW'(rel0_cnt - r0), 32'd1);
        check("dual_rel1", DW'(rel1_cnt - r1), 32'd1);

        // Random back-pressure over two banks.
        apply_reset();
        base = got_d.size(); s0 = stall_err;
        bank_rdy = 2'b11;
        run_beats(base + 128, 3000, 1'b1);
        m_axis_tready = 1'b1;
        check_stream(base, 2);
        check("stall_stable", DW'(stall_err - s0), 32'd0);

        // Only bank 1 ready: nothing may move until bank 0 is ready.
        apply_reset();
        base = got_d.size(); e0 = enb_cnt; t0 = tv_cnt;
        bank_rdy = 2'b10; m_axis_tready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check("b1_only_enb", DW'(enb_cnt - e0), 32'd0);
        check("b1_only_tvalid", DW'(tv_cnt - t0), 32'd0);
        bank_rdy = 2'b11;
        run_beats(base + 1, 50, 1'b0);
        check("b1_then_b0_first", got_d[base], 32'd0);

        // Reset in the middle of bank 0.
        apply_reset();
        base = got_d.size(); r0 = rel0_cnt;
        bank_rdy = 2'b01; m_axis_tready = 1'b1;
        run_beats(base + 21, 200, 1'b0);
        resetn = 1'b0;
        #1;
        check("midrst_ctrl", DW'({m_axis_tvalid, m_axis_tlast, enb, bank_rel, addrb}), '0);
        check("midrst_data", m_axis_tdata, '0);
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_rel", DW'(rel0_cnt - r0), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        base = got_d.size();
        run_beats(base + 64, 400, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_stream(base, 1);
        check("midrst_rel_after", DW'(rel0_cnt - r0), 32'd1);

        // Sink stalled from the start.
        apply_reset();
        base = got_d.size(); e0 = enb_cnt;
        bank_rdy = 2'b01; m_axis_tready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("hold_reads_le2", DW'((enb_cnt - e0) <= 2), 32'd1);
        check("hold_tvalid", DW'(m_axis_tvalid), 32'd1);
        check("hold_data", m_axis_tdata, 32'd0);
        check("hold_no_beats", DW'(got_d.size() - base), 32'd0);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        run_beats(base + 64, 400, 1'b0);
        check_stream(base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
